// File: rtl/exc_handler_if.sv
// Bus between the controller/datapath and the exception handler.
// The controller side drives the requests and PC; the handler side returns redirects and saved state.
interface exc_handler_if;
    logic        Exc;
    logic [3:0]  EStatus;
    logic        ERet;
    logic [63:0] PC;
    logic        ExcRedirect;
    logic        ERetRedirect;
    logic [63:0] ExcVector;
    logic        ExcAck;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        InHandler;
    logic [15:0] ExcCount;

    modport master (
        output Exc, EStatus, ERet, PC,
        input  ExcRedirect, ERetRedirect, ExcVector, ExcAck, ELR, ESR, InHandler, ExcCount
    );

    modport slave (
        input  Exc, EStatus, ERet, PC,
        output ExcRedirect, ERetRedirect, ExcVector, ExcAck, ELR, ESR, InHandler, ExcCount
    );
endinterface

// File: rtl/exc_handler.sv
// Exception/ERET sequencer: IDLE -> ACK -> HANDLER -> IDLE, saving return address and cause.
// Define EXC_CNT_EN to build the saturating exceptions-taken counter; otherwise ExcCount is tied to 0.
module exc_handler (
    input  logic        clk,
    input  logic        reset,
    exc_handler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACK     = 2'b01,
        HANDLER = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    localparam logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8;

    state_e      state_q, state_d;
    logic [63:0] elr_q, elr_d;
    logic [3:0]  esr_q, esr_d;
    logic        exc_redirect;
    logic        eret_redirect;
    logic        exc_taken;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        elr_d         = elr_q;
        esr_d         = esr_q;
        exc_redirect  = 1'b0;
        eret_redirect = 1'b0;
        exc_taken     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.Exc) begin
                    exc_redirect = 1'b1;
                    exc_taken    = 1'b1;
                    elr_d        = bus.PC;
                    esr_d        = bus.EStatus;
                    state_d      = ACK;
                end
            end
            ACK: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                // ERet wins over a simultaneous Exc; a held Exc is taken again from IDLE.
                if (bus.ERet) begin
                    eret_redirect = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            exc_redirect  = 1'b0;
            eret_redirect = 1'b0;
            exc_taken     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
            elr_q   <= '0;
            esr_q   <= '0;
        end else begin
            state_q <= state_d;
            elr_q   <= elr_d;
            esr_q   <= esr_d;
        end
    end

`ifdef EXC_CNT_EN
    logic [15:0] exc_cnt_q, exc_cnt_d;

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        if (exc_taken && (exc_cnt_q != 16'hFFFF)) begin
            exc_cnt_d = exc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign bus.ExcCount = exc_cnt_q;
`else
    assign bus.ExcCount = 16'h0000;
`endif

    assign bus.ExcRedirect  = exc_redirect;
    assign bus.ERetRedirect = eret_redirect;
    assign bus.ExcVector    = EXC_VECTOR;
    assign bus.ExcAck       = (state_q == ACK);
    assign bus.InHandler    = (state_q == HANDLER);
    assign bus.ELR          = elr_q;
    assign bus.ESR          = esr_q;

    redirect_exclusive: assert property (@(posedge clk) !(exc_redirect && eret_redirect));
    ack_only_in_ack:    assert property (@(posedge clk) bus.ExcAck |-> (state_q == ACK));

endmodule

// File: tb/tb_exc_handler.sv
// Directed bench for exc_handler: a per-cycle vector table plus latency and counter sequences.
module tb_exc_handler;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exc_handler_if bus ();

    exc_handler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef EXC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        exc;
        logic [3:0]  estatus;
        logic        eret;
        logic [63:0] pc;
        logic        e_exc_redir;
        logic        e_eret_redir;
        logic        e_ack;
        logic        e_inh;
        logic [63:0] e_elr;
        logic [3:0]  e_esr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] es,
                         input logic er, input logic [63:0] pc);
        reset       = r;
        bus.Exc     = e;
        bus.EStatus = es;
        bus.ERet    = er;
        bus.PC      = pc;
    endtask

    initial begin
        int first_inh;
        checks = 0;
        errors = 0;

        //                rst exc es     eret pc       exR eR  ack inh elr      esr    cnt
        vecs.push_back('{1, 1, 4'b0010, 0, 64'h010, 0, 0, 0, 0, 64'h000, 4'h0, 16'd0}); // reset blocks redirect
        vecs.push_back('{0, 0, 4'b0000, 1, 64'h020, 0, 0, 0, 0, 64'h000, 4'h0, 16'd0}); // ERet in IDLE ignored
        vecs.push_back('{0, 0, 4'b0000, 0, 64'h030, 0, 0, 0, 0, 64'h000, 4'h0, 16'd0});
        vecs.push_back('{0, 1, 4'b0010, 0, 64'h040, 1, 0, 0, 0, 64'h000, 4'h0, 16'd0}); // take exc
        vecs.push_back('{0, 0, 4'b0000, 0, 64'h044, 0, 0, 1, 0, 64'h040, 4'h2, 16'd1}); // ACK
        vecs.push_back('{0, 1, 4'b0001, 0, 64'h100, 0, 0, 0, 1, 64'h040, 4'h2, 16'd1}); // masked
        vecs.push_back('{0, 1, 4'b0001, 0, 64'h100, 0, 0, 0, 1, 64'h040, 4'h2, 16'd1});
        vecs.push_back('{0, 1, 4'b0001, 1, 64'h200, 0, 1, 0, 1, 64'h040, 4'h2, 16'd1}); // ERet wins
        vecs.push_back('{0, 1, 4'b0001, 0, 64'h300, 1, 0, 0, 0, 64'h040, 4'h2, 16'd1}); // held Exc taken
        vecs.push_back('{0, 0, 4'b0000, 0, 64'h304, 0, 0, 1, 0, 64'h300, 4'h1, 16'd2});
        vecs.push_back('{0, 0, 4'b0000, 0, 64'h400, 0, 0, 0, 1, 64'h300, 4'h1, 16'd2});
        vecs.push_back('{0, 0, 4'b0000, 1, 64'h404, 0, 1, 0, 1, 64'h300, 4'h1, 16'd2});
        vecs.push_back('{0, 1, 4'b0010, 0, 64'h500, 1, 0, 0, 0, 64'h300, 4'h1, 16'd2});
        vecs.push_back('{0, 1, 4'b0001, 1, 64'h504, 0, 0, 1, 0, 64'h500, 4'h2, 16'd3}); // ACK ignores inputs
        vecs.push_back('{1, 1, 4'b0001, 1, 64'h508, 0, 0, 0, 1, 64'h500, 4'h2, 16'd3}); // reset in HANDLER
        vecs.push_back('{0, 1, 4'b0001, 0, 64'h600, 1, 0, 0, 0, 64'h000, 4'h0, 16'd0}); // back in IDLE
        vecs.push_back('{1, 0, 4'b0000, 0, 64'h604, 0, 0, 1, 0, 64'h600, 4'h1, 16'd1}); // reset in ACK
        vecs.push_back('{0, 0, 4'b0000, 0, 64'h608, 0, 0, 0, 0, 64'h000, 4'h0, 16'd0});

        drive(1, 0, 4'h0, 0, 64'h0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].exc, vecs[i].estatus, vecs[i].eret, vecs[i].pc);
            #1;
            check($sformatf("r%0d ExcRedirect", i), 64'(bus.ExcRedirect), 64'(vecs[i].e_exc_redir));
            check($sformatf("r%0d ERetRedirect", i), 64'(bus.ERetRedirect), 64'(vecs[i].e_eret_redir));
            check($sformatf("r%0d ExcAck", i), 64'(bus.ExcAck), 64'(vecs[i].e_ack));
            check($sformatf("r%0d InHandler", i), 64'(bus.InHandler), 64'(vecs[i].e_inh));
            check($sformatf("r%0d ELR", i), bus.ELR, vecs[i].e_elr);
            check($sformatf("r%0d ESR", i), 64'(bus.ESR), 64'(vecs[i].e_esr));
            check($sformatf("r%0d ExcCount", i), 64'(bus.ExcCount), CNT_EN ? 64'(vecs[i].e_cnt) : 64'h0);
            check($sformatf("r%0d ExcVector", i), bus.ExcVector, 64'h0000_0000_0000_00D8);
        end

        // Latency: redirect at 0, ack at 1, HANDLER at 2 cycles after a single-cycle Exc.
        @(negedge clk);
        drive(0, 1, 4'b0010, 0, 64'h700);
        #1;
        check("lat redirect", 64'(bus.ExcRedirect), 64'h1);
        @(negedge clk);
        drive(0, 0, 4'b0000, 0, 64'h704);
        #1;
        check("lat ack", 64'(bus.ExcAck), 64'h1);
        first_inh = -1;
        for (int c = 2; c < 10; c++) begin
            if (c > 2) begin
                @(negedge clk);
                #1;
            end else begin
                @(negedge clk);
                #1;
            end
            if (bus.InHandler && first_inh < 0) first_inh = c;
            if (first_inh >= 0) break;
        end
        check("lat handler cycles", 64'(first_inh), 64'd2);
        check("lat ack dropped", 64'(bus.ExcAck), 64'h0);
        check("lat ELR", bus.ELR, 64'h700);

        drive(0, 0, 4'b0000, 1, 64'h708);
        #1;
        check("eret redirect", 64'(bus.ERetRedirect), 64'h1);
        @(negedge clk);
        drive(0, 0, 4'b0000, 0, 64'h70C);
        #1;
        check("eret back idle", 64'(bus.InHandler), 64'h0);
        check("count after trip", 64'(bus.ExcCount), CNT_EN ? 64'd1 : 64'd0);

`ifdef EXC_CNT_EN
        dut.exc_cnt_q = 16'hFFFF;
`endif
        @(negedge clk);
        drive(0, 1, 4'b0001, 0, 64'h800);
        #1;
        check("sat redirect", 64'(bus.ExcRedirect), 64'h1);
        @(negedge clk);
        drive(0, 0, 4'b0000, 0, 64'h804);
        #1;
        check("sat count", 64'(bus.ExcCount), CNT_EN ? 64'hFFFF : 64'h0);
        check("sat ELR", bus.ELR, 64'h800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
